// File: rtl/phase_gen_if.sv
// Control/status bundle between the phase generator and the control unit.
// The control unit owns the master side; phase_gen owns the slave side.
interface phase_gen_if #(
  parameter int NUM_PHASES = 4,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 8
);
  logic                  en;
  logic                  stall;
  logic                  last_ph;
  logic                  step_mode;
  logic                  step;
  logic [NUM_PHASES-1:0] t;
  logic [IDX_W-1:0]      ph_idx;
  logic                  running;
  logic                  cyc_end;
  logic [CNT_W-1:0]      cyc_cnt;

  modport master (
    output en, stall, last_ph, step_mode, step,
    input  t, ph_idx, running, cyc_end, cyc_cnt
  );

  modport slave (
    input  en, stall, last_ph, step_mode, step,
    output t, ph_idx, running, cyc_end, cyc_cnt
  );
endinterface

// File: rtl/phase_gen.sv
// Machine-cycle phase generator: one-hot phase t, phase index and retired-cycle
// counter, with run enable, stall, early termination and single-step control.
module phase_gen #(
  parameter int NUM_PHASES = 4,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  phase_gen_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] T0_HOT   = NUM_PHASES'(1);

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx_q, idx_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [NUM_PHASES-1:0] t_q, t_nxt;
  logic                  adv;
  logic                  cyc_end;

  assign adv     = (state == RUN) & ~bus.stall & (~bus.step_mode | bus.step);
  assign cyc_end = adv & ((idx_q == LAST_IDX) | bus.last_ph);

  // en is only consulted when a machine cycle retires, so a drop mid-cycle
  // lets the current cycle finish.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (bus.en) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        if (cyc_end) begin
          cnt_nxt = cnt_q + CNT_W'(1);
          idx_nxt = '0;
          if (!bus.en) begin
            state_nxt = IDLE;
          end
        end else if (adv) begin
          idx_nxt = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
    // Decoding t from the next index keeps it strictly one-hot or zero.
    t_nxt = (state_nxt == RUN) ? (T0_HOT << idx_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      t_q   <= '0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      cnt_q <= cnt_nxt;
      t_q   <= t_nxt;
    end
  end

  assign bus.t       = t_q;
  assign bus.ph_idx  = idx_q;
  assign bus.running = (state == RUN);
  assign bus.cyc_end = cyc_end;
  assign bus.cyc_cnt = cnt_q;

endmodule

// File: tb/tb_phase_gen.sv
// Bench for phase_gen: two instances (4 phases and 6 phases), a phase-number
// model compared every cycle, plus directed literal checks.
module tb_phase_gen;

  logic clk = 1'b0;
  logic rst4;
  logic rst6;
  bit   checking = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  phase_gen_if #(.NUM_PHASES(4), .IDX_W(2), .CNT_W(8)) bus4 ();
  phase_gen_if #(.NUM_PHASES(6), .IDX_W(3), .CNT_W(3)) bus6 ();

  phase_gen #(.NUM_PHASES(4), .IDX_W(2), .CNT_W(8)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  phase_gen #(.NUM_PHASES(6), .IDX_W(3), .CNT_W(3)) dut6 (
    .clk (clk),
    .rst (rst6),
    .bus (bus6)
  );

  // Model state: whether a machine cycle is in progress, which phase number
  // is active, and how many machine cycles have retired.
  typedef struct {
    bit run;
    int ph;
    int cnt;
  } mstate_t;

  mstate_t m4 = '{run: 1'b0, ph: 0, cnt: 0};
  mstate_t m6 = '{run: 1'b0, ph: 0, cnt: 0};

  function automatic bit model_moves(mstate_t s, logic stall, logic smode, logic stp);
    return s.run && !stall && (!smode || stp);
  endfunction

  function automatic bit model_ends(mstate_t s, int n, logic stall, logic last,
                                    logic smode, logic stp);
    return model_moves(s, stall, smode, stp) && ((s.ph == n - 1) || last);
  endfunction

  function automatic mstate_t model_next(mstate_t s, int n, int cw, logic r, logic en,
                                         logic stall, logic last, logic smode, logic stp);
    mstate_t ns = s;
    if (r) begin
      ns.run = 1'b0;
      ns.ph  = 0;
      ns.cnt = 0;
    end else if (!s.run) begin
      if (en) begin
        ns.run = 1'b1;
        ns.ph  = 0;
      end
    end else if (model_ends(s, n, stall, last, smode, stp)) begin
      ns.cnt = (s.cnt + 1) % (1 << cw);
      ns.ph  = 0;
      ns.run = en;
    end else if (model_moves(s, stall, smode, stp)) begin
      ns.ph = s.ph + 1;
    end
    return ns;
  endfunction

  function automatic logic [31:0] exp_t(mstate_t s);
    return s.run ? (32'd1 << s.ph) : 32'd0;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic en, logic stall, logic last, logic smode, logic stp);
    bus4.en        = en;
    bus4.stall     = stall;
    bus4.last_ph   = last;
    bus4.step_mode = smode;
    bus4.step      = stp;
    #1;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  always @(posedge clk) begin
    m4 = model_next(m4, 4, 8, rst4, bus4.en, bus4.stall, bus4.last_ph,
                    bus4.step_mode, bus4.step);
    m6 = model_next(m6, 6, 3, rst6, bus6.en, bus6.stall, bus6.last_ph,
                    bus6.step_mode, bus6.step);
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("m4 t",       32'(bus4.t),       exp_t(m4));
      checkOutput("m4 ph_idx",  32'(bus4.ph_idx),  32'(m4.ph));
      checkOutput("m4 running", 32'(bus4.running), 32'(m4.run));
      checkOutput("m4 cyc_end", 32'(bus4.cyc_end),
                  32'(model_ends(m4, 4, bus4.stall, bus4.last_ph, bus4.step_mode, bus4.step)));
      checkOutput("m4 cyc_cnt", 32'(bus4.cyc_cnt), 32'(m4.cnt));
      checkOutput("m6 t",       32'(bus6.t),       exp_t(m6));
      checkOutput("m6 ph_idx",  32'(bus6.ph_idx),  32'(m6.ph));
      checkOutput("m6 running", 32'(bus6.running), 32'(m6.run));
      checkOutput("m6 cyc_end", 32'(bus6.cyc_end),
                  32'(model_ends(m6, 6, bus6.stall, bus6.last_ph, bus6.step_mode, bus6.step)));
      checkOutput("m6 cyc_cnt", 32'(bus6.cyc_cnt), 32'(m6.cnt));
    end
  end

  initial begin
    rst4 = 1'b1;
    rst6 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus6.en = 1'b0; bus6.stall = 1'b0; bus6.last_ph = 1'b0;
    bus6.step_mode = 1'b0; bus6.step = 1'b0;
    tick(1);
    checking = 1'b1;
    tick(1);
    checkOutput("reset t", 32'(bus4.t), 32'h0);
    checkOutput("reset cnt", 32'(bus4.cyc_cnt), 32'h0);
    checkOutput("reset running", 32'(bus4.running), 32'h0);

    // Start: one clock of latency from en to T0
    rst4 = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post-reset t", 32'(bus4.t), 32'h0);
    tick(1);
    checkOutput("start T0", 32'(bus4.t), 32'h1);
    tick(3);
    checkOutput("first T3", 32'(bus4.t), 32'h8);
    checkOutput("T3 cyc_end", 32'(bus4.cyc_end), 32'h1);
    checkOutput("T3 cnt", 32'(bus4.cyc_cnt), 32'h0);
    tick(1);
    checkOutput("wrap T0", 32'(bus4.t), 32'h1);
    checkOutput("cnt after 1", 32'(bus4.cyc_cnt), 32'h1);
    tick(8);
    checkOutput("cnt after 12", 32'(bus4.cyc_cnt), 32'h3);

    // Stall held in T1 for three clocks
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("stall hold t", 32'(bus4.t), 32'h2);
    checkOutput("stall hold cnt", 32'(bus4.cyc_cnt), 32'h3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("stall release t", 32'(bus4.t), 32'h4);
    tick(2);
    checkOutput("stall cycle cnt", 32'(bus4.cyc_cnt), 32'h4);

    // Early termination in T1, then the same while stalled
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("early cyc_end", 32'(bus4.cyc_end), 32'h1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("early t", 32'(bus4.t), 32'h1);
    checkOutput("early cnt", 32'(bus4.cyc_cnt), 32'h5);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("early stalled cyc_end", 32'(bus4.cyc_end), 32'h0);
    tick(2);
    checkOutput("early stalled t", 32'(bus4.t), 32'h2);
    checkOutput("early stalled cnt", 32'(bus4.cyc_cnt), 32'h5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("early unstalled cyc_end", 32'(bus4.cyc_end), 32'h1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("early unstalled cnt", 32'(bus4.cyc_cnt), 32'h6);

    // en dropped in T1: cycle still completes
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("stop T2", 32'(bus4.t), 32'h4);
    tick(1);
    checkOutput("stop T3 running", 32'(bus4.running), 32'h1);
    tick(1);
    checkOutput("stop t", 32'(bus4.t), 32'h0);
    checkOutput("stop running", 32'(bus4.running), 32'h0);
    checkOutput("stop cnt", 32'(bus4.cyc_cnt), 32'h7);
    tick(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("restart T0", 32'(bus4.t), 32'h1);

    // Single-step: a pulse every fifth clock
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(4);
      checkOutput("step hold", 32'(bus4.t), 32'd1 << i);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("step cycle t", 32'(bus4.t), 32'h1);
    checkOutput("step cycle cnt", 32'(bus4.cyc_cnt), 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    checkOutput("step held T1", 32'(bus4.t), 32'h2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("free-run resume", 32'(bus4.t), 32'h4);
    tick(2);
    checkOutput("resume cnt", 32'(bus4.cyc_cnt), 32'h9);

    // Stall overrides en drop at the final phase
    tick(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("stall en-drop t", 32'(bus4.t), 32'h8);
    checkOutput("stall en-drop running", 32'(bus4.running), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("en-drop cyc_end", 32'(bus4.cyc_end), 32'h1);
    tick(1);
    checkOutput("en-drop idle", 32'(bus4.running), 32'h0);
    checkOutput("en-drop cnt", 32'(bus4.cyc_cnt), 32'hA);

    // Six-phase instance with a 3-bit counter
    rst6 = 1'b0;
    bus6.en = 1'b1;
    tick(1);
    checkOutput("p6 T0", 32'(bus6.t), 32'h1);
    tick(42);
    checkOutput("p6 cnt 7", 32'(bus6.cyc_cnt), 32'h7);
    tick(6);
    checkOutput("p6 cnt wrap", 32'(bus6.cyc_cnt), 32'h0);
    checkOutput("p6 wrap t", 32'(bus6.t), 32'h1);
    tick(4);
    checkOutput("p6 T4", 32'(bus6.t), 32'h10);
    rst6 = 1'b1;
    tick(1);
    checkOutput("p6 reset t", 32'(bus6.t), 32'h0);
    checkOutput("p6 reset cnt", 32'(bus6.cyc_cnt), 32'h0);
    rst6 = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
